// File: rtl/regfile_writeback.sv
// maxicore32 register file, flag register and condition evaluator, with a one-entry
// pending-writeback stage that aligns destination info with the ALU's one-cycle latency.
module regfile_writeback #(
   parameter int NUM_REGS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  read_addr2,
   input  logic [3:0]  read_addr3,
   output logic [31:0] reg2_data,
   output logic [31:0] reg3_data,
   input  logic        issue_valid,
   input  logic [3:0]  issue_dest,
   input  logic        issue_write,
   input  logic        issue_flags,
   input  logic [31:0] alu_result,
   input  logic        alu_carry,
   input  logic        alu_zero,
   input  logic        alu_neg,
   input  logic        alu_over,
   input  logic        load_write,
   input  logic [3:0]  load_addr,
   input  logic [31:0] load_data,
   output logic        load_ready,
   output logic        carry_flag,
   output logic [3:0]  flags,
   input  logic [3:0]  cond,
   output logic        cond_true
);

   logic [31:0] regs_r [NUM_REGS];
   logic [3:0]  flags_r;
   logic        pend_valid_r;
   logic [3:0]  pend_dest_r;
   logic        pend_write_r;
   logic        pend_flags_r;

   logic        pend_write_s;
   logic        pend_flags_s;
   logic [3:0]  alu_flags_s;
   logic [3:0]  eff_flags_s;

   assign pend_write_s = pend_valid_r & pend_write_r;
   assign pend_flags_s = pend_valid_r & pend_flags_r;
   assign alu_flags_s  = {alu_carry, alu_zero, alu_neg, alu_over};
   assign load_ready   = load_write & ~pend_write_s;
   assign flags        = flags_r;

   // Pending stage, register file and stored flags; the ALU writeback always beats the load port.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_valid_r <= 1'b0;
         pend_dest_r  <= 4'd0;
         pend_write_r <= 1'b0;
         pend_flags_r <= 1'b0;
         flags_r      <= 4'd0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 32'd0;
         end
      end else begin
         pend_valid_r <= issue_valid;
         pend_dest_r  <= issue_dest;
         pend_write_r <= issue_write & issue_valid;
         pend_flags_r <= issue_flags & issue_valid;
         if (pend_write_s) begin
            regs_r[pend_dest_r] <= alu_result;
         end else if (load_ready) begin
            regs_r[load_addr] <= load_data;
         end
         if (pend_flags_s) begin
            flags_r <= alu_flags_s;
         end
      end
   end

   // Operand read with forwarding: in-flight ALU result first, then the accepted load.
   always_comb begin
      reg2_data = regs_r[read_addr2];
      reg3_data = regs_r[read_addr3];
      if (pend_write_s && (read_addr2 == pend_dest_r)) begin
         reg2_data = alu_result;
      end else if (load_ready && (read_addr2 == load_addr)) begin
         reg2_data = load_data;
      end else begin
         reg2_data = regs_r[read_addr2];
      end
      if (pend_write_s && (read_addr3 == pend_dest_r)) begin
         reg3_data = alu_result;
      end else if (load_ready && (read_addr3 == load_addr)) begin
         reg3_data = load_data;
      end else begin
         reg3_data = regs_r[read_addr3];
      end
   end

   // Effective flags and condition evaluation; eff_flags_s is {C,Z,N,V}, C is borrow after subtract.
   always_comb begin
      eff_flags_s = flags_r;
      if (pend_flags_s) begin
         eff_flags_s = alu_flags_s;
      end else begin
         eff_flags_s = flags_r;
      end
      carry_flag = eff_flags_s[3];
      case (cond)
         4'd0:    cond_true = 1'b1;
         4'd1:    cond_true = eff_flags_s[2];
         4'd2:    cond_true = ~eff_flags_s[2];
         4'd3:    cond_true = eff_flags_s[3];
         4'd4:    cond_true = ~eff_flags_s[3];
         4'd5:    cond_true = eff_flags_s[1];
         4'd6:    cond_true = ~eff_flags_s[1];
         4'd7:    cond_true = eff_flags_s[0];
         4'd8:    cond_true = ~eff_flags_s[0];
         4'd9:    cond_true = ~eff_flags_s[3] & ~eff_flags_s[2];
         4'd10:   cond_true = eff_flags_s[3] | eff_flags_s[2];
         4'd11:   cond_true = (eff_flags_s[1] == eff_flags_s[0]);
         4'd12:   cond_true = (eff_flags_s[1] != eff_flags_s[0]);
         4'd13:   cond_true = ~eff_flags_s[2] & (eff_flags_s[1] == eff_flags_s[0]);
         4'd14:   cond_true = eff_flags_s[2] | (eff_flags_s[1] != eff_flags_s[0]);
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a behavioural model
// of the architectural state (register array, flags, pending writeback entry).
module tb_regfile_writeback;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  read_addr2, read_addr3, issue_dest, load_addr, cond;
   logic [31:0] reg2_data, reg3_data, alu_result, load_data;
   logic        issue_valid, issue_write, issue_flags;
   logic        alu_carry, alu_zero, alu_neg, alu_over;
   logic        load_write, load_ready, carry_flag, cond_true;
   logic [3:0]  flags;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_regs [16];
   logic [3:0]  m_flags;
   logic        m_pw, m_pf;
   logic [3:0]  m_pd;

   regfile_writeback #(.NUM_REGS(16)) dut (
      .clock(clock), .reset(reset),
      .read_addr2(read_addr2), .read_addr3(read_addr3),
      .reg2_data(reg2_data), .reg3_data(reg3_data),
      .issue_valid(issue_valid), .issue_dest(issue_dest),
      .issue_write(issue_write), .issue_flags(issue_flags),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .alu_neg(alu_neg), .alu_over(alu_over),
      .load_write(load_write), .load_addr(load_addr), .load_data(load_data),
      .load_ready(load_ready), .carry_flag(carry_flag), .flags(flags),
      .cond(cond), .cond_true(cond_true)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Condition table written directly from the architecture's flag meanings.
   function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
      logic cf, zf, nf, vf;
      {cf, zf, nf, vf} = f;
      case (c)
         4'd0:    return 1'b1;
         4'd1:    return zf;
         4'd2:    return !zf;
         4'd3:    return cf;
         4'd4:    return !cf;
         4'd5:    return nf;
         4'd6:    return !nf;
         4'd7:    return vf;
         4'd8:    return !vf;
         4'd9:    return !cf && !zf;
         4'd10:   return cf || zf;
         4'd11:   return nf == vf;
         4'd12:   return nf != vf;
         4'd13:   return !zf && (nf == vf);
         4'd14:   return zf || (nf != vf);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] read_model(input logic [3:0] a);
      if (m_pw && a == m_pd) return alu_result;
      if (load_write && !m_pw && a == load_addr) return load_data;
      return m_regs[a];
   endfunction

   task automatic idle_inputs();
      issue_valid = 1'b0; issue_dest = 4'd0; issue_write = 1'b0; issue_flags = 1'b0;
      alu_result = 32'd0; {alu_carry, alu_zero, alu_neg, alu_over} = 4'd0;
      load_write = 1'b0; load_addr = 4'd0; load_data = 32'd0;
      read_addr2 = 4'd0; read_addr3 = 4'd0; cond = 4'd0;
   endtask

   // Called at the negedge with inputs set: checks outputs, then advances model one edge.
   task automatic cycle();
      logic [3:0] eff;
      #1;
      eff = m_pf ? {alu_carry, alu_zero, alu_neg, alu_over} : m_flags;
      check_val("reg2_data", reg2_data, read_model(read_addr2));
      check_val("reg3_data", reg3_data, read_model(read_addr3));
      check_val("load_ready", {31'd0, load_ready}, {31'd0, load_write && !m_pw});
      check_val("carry_flag", {31'd0, carry_flag}, {31'd0, eff[3]});
      check_val("flags", {28'd0, flags}, {28'd0, m_flags});
      check_val("cond_true", {31'd0, cond_true}, {31'd0, cond_model(cond, eff)});
      @(posedge clock);
      if (reset) begin
         for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
         m_flags = 4'd0; m_pw = 1'b0; m_pf = 1'b0; m_pd = 4'd0;
      end else begin
         if (m_pw) m_regs[m_pd] = alu_result;
         else if (load_write) m_regs[load_addr] = load_data;
         if (m_pf) m_flags = {alu_carry, alu_zero, alu_neg, alu_over};
         m_pw = issue_valid && issue_write;
         m_pf = issue_valid && issue_flags;
         m_pd = issue_dest;
      end
      @(negedge clock);
   endtask

   initial begin
      logic [15:0] cond_mask;
      cond_mask = 16'h2B55;
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_flags = 4'd0; m_pw = 1'b0; m_pf = 1'b0; m_pd = 4'd0;
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      cycle();
      reset = 1'b0;

      // Reset state: all registers zero, condition sweep on zero flags
      for (int i = 0; i < 16; i++) begin
         read_addr2 = i[3:0]; read_addr3 = 4'(15 - i); cond = i[3:0];
         #1;
         check_val("reset_reg", reg2_data, 32'd0);
         check_val("reset_cond", {31'd0, cond_true}, {31'd0, cond_mask[i]});
         cycle();
      end

      // ALU write to r3 with forwarding then plain read
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 4'd3; issue_write = 1'b1;
      cycle();
      idle_inputs();
      alu_result = 32'h12345678; read_addr2 = 4'd3;
      #1 check_val("fwd_r3", reg2_data, 32'h12345678);
      cycle();
      alu_result = 32'hCAFEF00D;
      #1 check_val("plain_r3", reg2_data, 32'h12345678);
      cycle();

      // ADD sets carry, ADDC issued back-to-back sees forwarded carry
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 4'd4; issue_flags = 1'b1;
      cycle();
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 4'd4; alu_carry = 1'b1;
      #1 check_val("addc_carry", {31'd0, carry_flag}, 32'd1);
      cycle();
      idle_inputs();
      #1 check_val("stored_flags", {28'd0, flags}, 32'h8);
      cycle();

      // Load refused while an ALU write is pending, accepted next cycle
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 4'd2; issue_write = 1'b1;
      cycle();
      idle_inputs();
      alu_result = 32'h00000022;
      load_write = 1'b1; load_addr = 4'd5; load_data = 32'hDEADBEEF; read_addr2 = 4'd5;
      #1 check_val("load_refused", {31'd0, load_ready}, 32'd0);
      check_val("r5_unchanged", reg2_data, 32'd0);
      cycle();
      alu_result = 32'd0;
      #1 check_val("load_accepted", {31'd0, load_ready}, 32'd1);
      cycle();
      idle_inputs();
      read_addr2 = 4'd5;
      #1 check_val("r5_loaded", reg2_data, 32'hDEADBEEF);
      cycle();

      // COMP: flag update without register write
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 4'd1; issue_write = 1'b1;
      cycle();
      idle_inputs();
      alu_result = 32'h55;
      cycle();
      issue_valid = 1'b1; issue_dest = 4'd1; issue_flags = 1'b1;
      cycle();
      idle_inputs();
      alu_result = 32'hAAAA0000; alu_zero = 1'b1; cond = 4'd1; read_addr2 = 4'd1;
      #1 check_val("comp_eq", {31'd0, cond_true}, 32'd1);
      check_val("comp_r1", reg2_data, 32'h55);
      cycle();
      idle_inputs();
      read_addr2 = 4'd1;
      #1 check_val("comp_r1_after", reg2_data, 32'h55);
      check_val("comp_z", {31'd0, flags[2]}, 32'd1);
      cycle();

      // Reset discards a pending write and flag update
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 4'd7; issue_write = 1'b1; issue_flags = 1'b1;
      cycle();
      idle_inputs();
      alu_result = 32'hFFFFFFFF; {alu_carry, alu_zero, alu_neg, alu_over} = 4'hF;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      idle_inputs();
      read_addr2 = 4'd7;
      #1 check_val("rst_r7", reg2_data, 32'd0);
      check_val("rst_flags", {28'd0, flags}, 32'd0);
      cycle();

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 59) == 0);
         issue_valid = $urandom_range(0, 1);
         issue_dest = 4'($urandom_range(0, 15));
         issue_write = $urandom_range(0, 1);
         issue_flags = $urandom_range(0, 1);
         alu_result = $urandom;
         {alu_carry, alu_zero, alu_neg, alu_over} = 4'($urandom_range(0, 15));
         load_write = $urandom_range(0, 1);
         load_addr = 4'($urandom_range(0, 15));
         load_data = $urandom;
         read_addr2 = (m_pw && $urandom_range(0, 2) == 0) ? m_pd : 4'($urandom_range(0, 15));
         read_addr3 = ($urandom_range(0, 2) == 0) ? load_addr : 4'($urandom_range(0, 15));
         cond = 4'($urandom_range(0, 15));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
